// File: rtl/arp_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
// Module  : arp_tx_pkg
// Purpose : Shared Ethernet/ARP constants, section lengths and FSM encoding.
// Revision: 1.0
//----------------------------------------------------------------------------
package arp_tx_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE       = 16'h0001;
    localparam logic [15:0] ARP_PTYPE       = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'h06;
    localparam logic [7:0]  ARP_PLEN        = 8'h04;
    localparam logic [15:0] ARP_OP_REQ      = 16'h0001;
    localparam logic [15:0] ARP_OP_REP      = 16'h0002;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

    localparam logic [7:0]  PREAMBLE_LEN    = 8'd8;
    localparam logic [7:0]  ETH_HEAD_LEN    = 8'd14;
    localparam logic [7:0]  ARP_DATA_LEN    = 8'd28;
    localparam logic [7:0]  PAD_LEN         = 8'd18;
    localparam logic [7:0]  FCS_LEN         = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH_HEAD = 3'd2,
        ST_ARP_DATA = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } arp_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/arp_tx_crc32_d8.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
// Module  : crc32_d8
// Purpose : Byte-wide reflected Ethernet CRC-32; o_crc is the final complement.
// Revision: 1.0
//----------------------------------------------------------------------------
module crc32_d8
    import arp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_en,
    input  logic        i_clr,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // LSB-first bitwise division, unrolled over the 8 data bits
    always_comb begin
        w_crc_next = r_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc_next = w_crc_next[0] ? ((w_crc_next >> 1) ^ CRC32_POLY_REFL)
                                       : (w_crc_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC32_INIT;
        end else if (i_clr) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/arp_tx.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
// Module  : arp_tx
// Purpose : Serialises one Ethernet II ARP request/reply frame onto GMII tx.
// Revision: 1.0
//----------------------------------------------------------------------------
module arp_tx
    import arp_tx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = 32'hC0_A8_01_0A,
    parameter logic [31:0] DES_IP     = 32'hC0_A8_01_66,
    parameter int          IFG_CYCLES = 12
)(
    input  logic        i_crtl_clk,
    input  logic        i_rst_n,
    input  logic        i_arp_tx_en,
    input  logic        i_arp_tx_type,
    input  logic [47:0] i_arp_tx_desmac_addr,
    input  logic [31:0] i_arp_tx_desip_addr,
    output logic        o_arp_tx_valid,
    output logic        o_arp_tx_done,
    output logic        o_gmii_tx_en,
    output logic [7:0]  o_gmii_txd
);

    localparam logic [7:0] c_ifg_last = 8'(IFG_CYCLES - 1);

    arp_tx_state_t      r_state;
    arp_tx_state_t      w_state_next;
    logic [7:0]         r_cnt;
    logic               w_last;

    logic               r_type;
    logic [47:0]        r_desmac;
    logic [31:0]        r_desip;

    logic [47:0]        w_dst_mac;
    logic [47:0]        w_tgt_mac;
    logic [31:0]        w_tgt_ip;
    logic [15:0]        w_opcode;
    logic [13:0][7:0]   w_eth_head;
    logic [27:0][7:0]   w_arp_data;
    logic [3:0][7:0]    w_fcs;
    logic [31:0]        w_crc;
    logic               w_crc_en;

    always_ff @(posedge i_crtl_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_type   <= 1'b0;
            r_desmac <= '0;
            r_desip  <= '0;
        end else if (r_state == ST_IDLE && i_arp_tx_en) begin
            r_type   <= i_arp_tx_type;
            r_desmac <= i_arp_tx_desmac_addr;
            r_desip  <= i_arp_tx_desip_addr;
        end
    end

    assign w_dst_mac  = r_type ? r_desmac : 48'hFFFF_FFFF_FFFF;
    assign w_tgt_mac  = r_type ? r_desmac : 48'h0;
    assign w_tgt_ip   = (!r_type && r_desip == 32'h0) ? DES_IP : r_desip;
    assign w_opcode   = r_type ? ARP_OP_REP : ARP_OP_REQ;
    assign w_eth_head = {w_dst_mac, BOARD_MAC, ETH_TYPE_ARP};
    assign w_arp_data = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, w_opcode,
                         BOARD_MAC, BOARD_IP, w_tgt_mac, w_tgt_ip};
    assign w_fcs      = w_crc;

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arp_tx_en) w_state_next = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                w_last = (r_cnt == PREAMBLE_LEN - 8'd1);
                if (w_last) w_state_next = ST_ETH_HEAD;
            end
            ST_ETH_HEAD: begin
                w_last = (r_cnt == ETH_HEAD_LEN - 8'd1);
                if (w_last) w_state_next = ST_ARP_DATA;
            end
            ST_ARP_DATA: begin
                w_last = (r_cnt == ARP_DATA_LEN - 8'd1);
                if (w_last) w_state_next = ST_PAD;
            end
            ST_PAD: begin
                w_last = (r_cnt == PAD_LEN - 8'd1);
                if (w_last) w_state_next = ST_FCS;
            end
            ST_FCS: begin
                w_last = (r_cnt == FCS_LEN - 8'd1);
                if (w_last) w_state_next = ST_IFG;
            end
            ST_IFG: begin
                w_last = (r_cnt == c_ifg_last);
                if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_crtl_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state || r_state == ST_IDLE) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    // Outputs decode straight from the state register so reset clears them at once
    always_comb begin
        o_gmii_tx_en = 1'b0;
        o_gmii_txd   = 8'h00;
        case (r_state)
            ST_PREAMBLE: begin
                o_gmii_tx_en = 1'b1;
                o_gmii_txd   = w_last ? SFD_BYTE : PREAMBLE_BYTE;
            end
            ST_ETH_HEAD: begin
                o_gmii_tx_en = 1'b1;
                o_gmii_txd   = w_eth_head[4'd13 - r_cnt[3:0]];
            end
            ST_ARP_DATA: begin
                o_gmii_tx_en = 1'b1;
                o_gmii_txd   = w_arp_data[5'd27 - r_cnt[4:0]];
            end
            ST_PAD: begin
                o_gmii_tx_en = 1'b1;
            end
            ST_FCS: begin
                o_gmii_tx_en = 1'b1;
                o_gmii_txd   = w_fcs[r_cnt[1:0]];
            end
            default: ;
        endcase
    end

    assign o_arp_tx_valid = (r_state == ST_IDLE);
    assign o_arp_tx_done  = (r_state == ST_IFG) && (r_cnt == 8'd0);
    assign w_crc_en       = (r_state == ST_ETH_HEAD) || (r_state == ST_ARP_DATA) ||
                            (r_state == ST_PAD);

    crc32_d8 u_crc32_d8 (
        .clk    (i_crtl_clk),
        .rst_n  (i_rst_n),
        .i_data (o_gmii_txd),
        .i_en   (w_crc_en),
        .i_clr  (r_state == ST_IDLE),
        .o_crc  (w_crc)
    );

endmodule
`default_nettype wire

// File: tb/tb_arp_tx.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
// Module  : tb_arp_tx
// Purpose : Frame-level model of arp_tx with a per-cycle output compare.
// Revision: 1.0
//----------------------------------------------------------------------------
module tb_arp_tx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        typ   = 1'b0;
    logic [47:0] mac   = '0;
    logic [31:0] ip    = '0;
    logic        valid, done, tx_en;
    logic [7:0]  txd;

    arp_tx dut (
        .i_crtl_clk           (clk),
        .i_rst_n              (rst_n),
        .i_arp_tx_en          (en),
        .i_arp_tx_type        (typ),
        .i_arp_tx_desmac_addr (mac),
        .i_arp_tx_desip_addr  (ip),
        .o_arp_tx_valid       (valid),
        .o_arp_tx_done        (done),
        .o_gmii_tx_en         (tx_en),
        .o_gmii_txd           (txd)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] txd;
        logic       valid;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_EXP = '{1'b0, 8'h00, 1'b1, 1'b0};

    exp_t        expq[$];
    logic [7:0]  fr [72];
    int          wp;
    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] v;
        v = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    task automatic put(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            fr[wp] = 8'(v >> (8 * (n - 1 - i)));
            wp++;
        end
    endtask

    // Whole 72-byte wire image built from field definitions
    task automatic build_frame(input logic t, input logic [47:0] m, input logic [31:0] a);
        logic [31:0] c;
        wp = 0;
        for (int i = 0; i < 7; i++) put(64'h55, 1);
        put(64'hD5, 1);
        put(t ? {16'h0, m} : 64'hFFFF_FFFF_FFFF, 6);
        put({16'h0, BOARD_MAC}, 6);
        put(64'h0806, 2);
        put(64'h0001, 2);
        put(64'h0800, 2);
        put(64'h06, 1);
        put(64'h04, 1);
        put(t ? 64'h2 : 64'h1, 2);
        put({16'h0, BOARD_MAC}, 6);
        put({32'h0, BOARD_IP}, 4);
        put(t ? {16'h0, m} : 64'h0, 6);
        put((!t && a == 0) ? 64'hC0A80166 : {32'h0, a}, 4);
        for (int i = 0; i < 18; i++) put(64'h0, 1);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) c = crc_step(c, fr[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) put({56'h0, c[8*i +: 8]}, 1);
    endtask

    // Model: front of queue is this cycle's expectation; accept only when idle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
        end else if (expq.size() > 0) begin
            void'(expq.pop_front());
        end else if (en) begin
            build_frame(typ, mac, ip);
            for (int i = 0; i < 72; i++) expq.push_back('{1'b1, fr[i], 1'b0, 1'b0});
            expq.push_back('{1'b0, 8'h00, 1'b0, 1'b1});
            for (int i = 0; i < 11; i++) expq.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = (rst_n && expq.size() > 0) ? expq[0] : IDLE_EXP;
        chk("cycle {en,txd,valid,done}", {54'h0, tx_en, txd, valid, done}, {54'h0, e});
        if (done) done_cnt++;
    end

    task automatic send(input logic t, input logic [47:0] m, input logic [31:0] a, input int hold);
        @(posedge clk); #1;
        typ = t; mac = m; ip = a; en = 1'b1;
        repeat (hold) @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("idle_timeout", {63'h0, k >= 300}, 64'h0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int d0, k;

        // Pin the model against hand-derived bytes
        d0 = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) d0 = crc_step(d0, 8'h31 + 8'(i));
        chk("pin crc 123456789", {32'h0, ~d0}, 64'hCBF43926);
        build_frame(1'b0, 48'h0, 32'hC0A80166);
        chk("pin preamble0", {56'h0, fr[0]}, 64'h55);
        chk("pin sfd", {56'h0, fr[7]}, 64'hD5);
        chk("pin req dmac", {56'h0, fr[8]}, 64'hFF);
        chk("pin ethertype lo", {56'h0, fr[21]}, 64'h06);
        chk("pin req opcode lo", {56'h0, fr[29]}, 64'h01);
        build_frame(1'b1, 48'hD8BBC10A0B0C, 32'hC0A80102);
        chk("pin rep dmac0", {56'h0, fr[8]}, 64'hD8);
        chk("pin rep dmac5", {56'h0, fr[13]}, 64'h0C);
        chk("pin rep opcode lo", {56'h0, fr[29]}, 64'h02);
        chk("pin rep tmac0", {56'h0, fr[40]}, 64'hD8);
        build_frame(1'b0, 48'h0, 32'h0);
        chk("pin zero-ip tip0", {56'h0, fr[46]}, 64'hC0);
        chk("pin zero-ip tip3", {56'h0, fr[49]}, 64'h66);

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", {63'h0, valid}, 64'h1);
        chk("reset tx_en", {63'h0, tx_en}, 64'h0);
        chk("reset txd", {56'h0, txd}, 64'h0);
        chk("reset done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Request: first preamble byte right after the accepting edge
        d0 = done_cnt;
        send(1'b0, 48'h0, 32'hC0A80166, 1);
        chk("latency tx_en", {63'h0, tx_en}, 64'h1);
        chk("latency txd", {56'h0, txd}, 64'h55);
        wait_idle();
        chk("request done count", 64'(done_cnt - d0), 64'd1);

        // Reply: valid low for 72 bytes plus 12 IFG cycles
        send(1'b1, 48'hD8BBC10A0B0C, 32'hC0A80102, 1);
        k = 0;
        while (!valid && k < 200) begin
            @(negedge clk);
            if (!valid) k++;
        end
        chk("reply valid-low cycles", 64'(k), 64'd84);
        wait_idle();

        send(1'b0, 48'h0, 32'h0, 1);
        wait_idle();

        // Long en pulse plus a stray en mid-frame
        d0 = done_cnt;
        send(1'b0, 48'hAABBCCDDEEFF, 32'hC0A80133, 5);
        repeat (20) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle();
        chk("multi-en done count", 64'(done_cnt - d0), 64'd1);

        // Reset while byte 30 is on the wire
        send(1'b1, 48'h0102030405A6, 32'hC0A80177, 1);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        d0 = done_cnt;
        #1;
        chk("midreset tx_en", {63'h0, tx_en}, 64'h0);
        chk("midreset valid", {63'h0, valid}, 64'h1);
        chk("midreset txd", {56'h0, txd}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        chk("midreset no done", 64'(done_cnt - d0), 64'd0);
        send(1'b0, 48'h0, 32'hC0A80155, 1);
        wait_idle();
        chk("post-reset done count", 64'(done_cnt - d0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
